// File: rtl/sd_image_arbiter.sv
// rtl/sd_image_arbiter.sv - round-robin arbiter for the shared SD block-device port
//
// Purpose: grants the SD port to either the floppy track buffer (two images)
// or the SCSI target (one image). It latches the owner's LBA and direction,
// sequences the SD handshake and gates returned byte strobes to the owner.
//
// Ports:
//   clk_i, reset_ni        clock, synchronous active-low reset
//   flp_rd_i[1:0]          floppy read request level per image
//   flp_lba_i[31:0]        floppy block address
//   flp_busy_o/done_o/err_o/data_en_o  floppy status, pulses and gated strobe
//   scsi_rd_i, scsi_wr_i   SCSI read/write request levels
//   scsi_lba_i[31:0]       SCSI block address
//   scsi_busy_o/done_o/err_o/data_en_o SCSI status, pulses and gated strobe
//   sd_lba_o[31:0]         latched LBA of the current owner
//   sd_rd_o[2:0]           per-image read strobe (0/1 floppy, 2 SCSI)
//   sd_wr_o[2:0]           per-image write strobe (only bit 2 used)
//   sd_busy_i, sd_done_i, sd_data_en_i  SD host handshake and byte strobe
//
// Build option: SD_IMAGE_ARB_WRITE_EN enables SCSI writes; when undefined
// scsi_wr_i is ignored and sd_wr_o is constant 0.

module sd_image_arbiter #(
   parameter int unsigned ACK_TIMEOUT = 1048576
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic [1:0]  flp_rd_i,
   input  logic [31:0] flp_lba_i,
   output logic        flp_busy_o,
   output logic        flp_done_o,
   output logic        flp_err_o,
   output logic        flp_data_en_o,
   input  logic        scsi_rd_i,
   input  logic        scsi_wr_i,
   input  logic [31:0] scsi_lba_i,
   output logic        scsi_busy_o,
   output logic        scsi_done_o,
   output logic        scsi_err_o,
   output logic        scsi_data_en_o,
   output logic [31:0] sd_lba_o,
   output logic [2:0]  sd_rd_o,
   output logic [2:0]  sd_wr_o,
   input  logic        sd_busy_i,
   input  logic        sd_done_i,
   input  logic        sd_data_en_i
);

`ifdef SD_IMAGE_ARB_WRITE_EN
   localparam logic WR_EN = 1'b1;
`else
   localparam logic WR_EN = 1'b0;
`endif

   localparam logic [20:0] ACK_LAST = 21'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_XFER,
      S_DONE,
      S_RELEASE
   } state_e;

   state_e      state_q, state_d;
   logic        owner_scsi_q, owner_scsi_d;
   logic [1:0]  img_q, img_d;
   logic [31:0] lba_q, lba_d;
   logic        wr_q, wr_d;
   logic        last_scsi_q, last_scsi_d;
   logic [20:0] cnt_q, cnt_d;
   logic        err_q, err_d;

   logic flp_req, scsi_req, owner_req, grant_scsi, strobe_on, xfer, done;

   assign flp_req    = |flp_rd_i;
   assign scsi_req   = scsi_rd_i | (scsi_wr_i & WR_EN);
   assign owner_req  = owner_scsi_q ? scsi_req : flp_req;
   // On a tie the client that did not win the last completed grant goes first.
   assign grant_scsi = scsi_req & (~flp_req | ~last_scsi_q);

   always_comb begin
      state_d      = state_q;
      owner_scsi_d = owner_scsi_q;
      img_d        = img_q;
      lba_d        = lba_q;
      wr_d         = wr_q;
      last_scsi_d  = last_scsi_q;
      cnt_d        = cnt_q;
      err_d        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (flp_req || scsi_req) begin
               state_d      = S_ISSUE;
               owner_scsi_d = grant_scsi;
               cnt_d        = '0;
               if (grant_scsi) begin
                  img_d = 2'd2;
                  lba_d = scsi_lba_i;
                  // Read wins when both directions are requested.
                  wr_d  = ~scsi_rd_i & WR_EN;
               end else begin
                  img_d = flp_rd_i[0] ? 2'd0 : 2'd1;
                  lba_d = flp_lba_i;
                  wr_d  = 1'b0;
               end
            end
         end
         S_ISSUE: begin
            if (sd_busy_i) begin
               state_d = S_XFER;
            end else if (cnt_q == ACK_LAST) begin
               state_d = S_RELEASE;
               err_d   = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 21'd1;
            end
         end
         S_XFER: begin
            if (sd_done_i) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            last_scsi_d = owner_scsi_q;
            // Skipping RELEASE when already clear allows a grant two cycles after sd_done.
            if (!owner_req && !sd_busy_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!owner_req && !sd_busy_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q      <= S_IDLE;
         owner_scsi_q <= 1'b0;
         img_q        <= 2'd0;
         lba_q        <= '0;
         wr_q         <= 1'b0;
         last_scsi_q  <= 1'b1;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_scsi_q <= owner_scsi_d;
         img_q        <= img_d;
         lba_q        <= lba_d;
         wr_q         <= wr_d;
         last_scsi_q  <= last_scsi_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   assign strobe_on = (state_q == S_ISSUE) || (state_q == S_XFER);
   assign xfer      = (state_q == S_XFER);
   assign done      = (state_q == S_DONE);

   assign sd_lba_o = lba_q;
   assign sd_rd_o  = (strobe_on && !wr_q) ? (3'b001 << img_q) : 3'b000;
   assign sd_wr_o  = {strobe_on & wr_q & WR_EN, 2'b00};

   assign flp_busy_o     = (state_q != S_IDLE) & ~owner_scsi_q;
   assign flp_done_o     = done & ~owner_scsi_q;
   assign flp_err_o      = err_q & ~owner_scsi_q;
   assign flp_data_en_o  = xfer & ~owner_scsi_q & sd_data_en_i;

   assign scsi_busy_o    = (state_q != S_IDLE) & owner_scsi_q;
   assign scsi_done_o    = done & owner_scsi_q;
   assign scsi_err_o     = err_q & owner_scsi_q;
   assign scsi_data_en_o = xfer & owner_scsi_q & sd_data_en_i;

endmodule

// File: tb/tb_sd_image_arbiter.sv
// tb/tb_sd_image_arbiter.sv - self-checking bench for sd_image_arbiter
module tb_sd_image_arbiter;

`ifdef SD_IMAGE_ARB_WRITE_EN
   localparam bit WREN = 1'b1;
`else
   localparam bit WREN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic [1:0]  flp_rd_i;
   logic [31:0] flp_lba_i;
   logic        flp_busy_o, flp_done_o, flp_err_o, flp_data_en_o;
   logic        scsi_rd_i, scsi_wr_i;
   logic [31:0] scsi_lba_i;
   logic        scsi_busy_o, scsi_done_o, scsi_err_o, scsi_data_en_o;
   logic [31:0] sd_lba_o;
   logic [2:0]  sd_rd_o, sd_wr_o;
   logic        sd_busy_i, sd_done_i, sd_data_en_i;

   int n_tests = 0;
   int n_fail  = 0;
   bit last_scsi;

   sd_image_arbiter #(.ACK_TIMEOUT(16)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .flp_rd_i(flp_rd_i), .flp_lba_i(flp_lba_i),
      .flp_busy_o(flp_busy_o), .flp_done_o(flp_done_o), .flp_err_o(flp_err_o),
      .flp_data_en_o(flp_data_en_o),
      .scsi_rd_i(scsi_rd_i), .scsi_wr_i(scsi_wr_i), .scsi_lba_i(scsi_lba_i),
      .scsi_busy_o(scsi_busy_o), .scsi_done_o(scsi_done_o), .scsi_err_o(scsi_err_o),
      .scsi_data_en_o(scsi_data_en_o),
      .sd_lba_o(sd_lba_o), .sd_rd_o(sd_rd_o), .sd_wr_o(sd_wr_o),
      .sd_busy_i(sd_busy_i), .sd_done_i(sd_done_i), .sd_data_en_i(sd_data_en_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   typedef struct {
      logic [1:0]  flp;
      logic        srd;
      logic        swr;
      logic [31:0] flba;
      logic [31:0] slba;
      logic [2:0]  exp_rd;
      logic [2:0]  exp_wr;
      logic [31:0] exp_lba;
      logic        exp_scsi;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({sd_rd_o, sd_wr_o, sd_lba_o, flp_busy_o, flp_done_o, flp_err_o, flp_data_en_o,
                  scsi_busy_o, scsi_done_o, scsi_err_o, scsi_data_en_o});
   endfunction

   function automatic int de_of(input bit scsi_side);
      return scsi_side ? int'(scsi_data_en_o) : int'(flp_data_en_o);
   endfunction

   // Starts in the first ISSUE cycle; ends in the DONE cycle after checking it.
   task automatic run_xfer(input bit own, input int ack_dly, input int nbeats, input bit rnd,
                           input logic [31:0] exp_lba);
      int got_own, got_oth, exp_cnt;
      got_own = 0; got_oth = 0; exp_cnt = 0;
      for (int i = 0; i < ack_dly; i++) begin
         sd_busy_i    = 1'b0;
         sd_data_en_i = 1'($urandom_range(0, 1));
         sd_done_i    = 1'($urandom_range(0, 1));
         #1; got_own += de_of(own); got_oth += de_of(!own);
         cyc();
      end
      sd_busy_i = 1'b1; sd_done_i = 1'b0; sd_data_en_i = 1'($urandom_range(0, 1));
      #1; got_own += de_of(own); got_oth += de_of(!own);
      cyc();
      for (int i = 0; i < nbeats; i++) begin
         sd_data_en_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         exp_cnt += int'(sd_data_en_i);
         #1; got_own += de_of(own); got_oth += de_of(!own);
         cyc();
      end
      sd_done_i = 1'b1; sd_data_en_i = 1'b0;
      #1; got_own += de_of(own); got_oth += de_of(!own);
      chk("strobe_held", 64'((sd_rd_o | sd_wr_o) != 3'b000), 64'd1);
      cyc();
      sd_done_i = 1'b0; sd_data_en_i = 1'b1;
      #1; got_own += de_of(own); got_oth += de_of(!own);
      chk("done_owner", 64'(own ? scsi_done_o : flp_done_o), 64'd1);
      chk("done_other", 64'(own ? flp_done_o : scsi_done_o), 64'd0);
      chk("strobe_off", 64'({sd_rd_o, sd_wr_o}), 64'd0);
      chk("err_none", 64'({flp_err_o, scsi_err_o}), 64'd0);
      chk("lba_latched", 64'(sd_lba_o), 64'(exp_lba));
      chk("data_en_owner", 64'(got_own), 64'(exp_cnt));
      chk("data_en_other", 64'(got_oth), 64'd0);
      sd_data_en_i = 1'b0;
   endtask

   task automatic release_all();
      int n;
      sd_busy_i = 1'b0; flp_rd_i = 2'b00; scsi_rd_i = 1'b0; scsi_wr_i = 1'b0;
      sd_data_en_i = 1'b0; sd_done_i = 1'b0;
      cyc(); #1;
      chk("done_one_cycle", 64'({flp_done_o, scsi_done_o}), 64'd0);
      n = 0;
      while ((flp_busy_o || scsi_busy_o) && n < 8) begin
         cyc(); #1; n++;
      end
      chk("idle_after_release", 64'({flp_busy_o, scsi_busy_o}), 64'd0);
   endtask

   initial begin
      int strobe_cyc, errs, dones, bad;
      logic [1:0]  f;
      logic        sr, sw, win;
      logic [31:0] fl, sl, elba;
      logic [2:0]  erd, ewr;

      tbl[0] = '{2'b01, 1'b1, 1'b0, 32'h10,  32'h20,  3'b001, 3'b000, 32'h10,  1'b0};
      tbl[1] = '{2'b01, 1'b1, 1'b0, 32'h11,  32'h21,  3'b100, 3'b000, 32'h21,  1'b1};
      tbl[2] = '{2'b10, 1'b0, 1'b0, 32'h123, 32'h0,   3'b010, 3'b000, 32'h123, 1'b0};
      tbl[3] = '{2'b11, 1'b0, 1'b0, 32'h55,  32'h0,   3'b001, 3'b000, 32'h55,  1'b0};
      tbl[4] = '{2'b00, 1'b1, 1'b0, 32'h0,   32'h5,   3'b100, 3'b000, 32'h5,   1'b1};
      tbl[5] = '{2'b11, 1'b1, 1'b0, 32'hAAAA5555, 32'h1, 3'b001, 3'b000, 32'hAAAA5555, 1'b0};
      tbl[6] = '{2'b10, 1'b1, 1'b0, 32'h2, 32'hFFFFFFFF, 3'b100, 3'b000, 32'hFFFFFFFF, 1'b1};
      tbl[7] = '{2'b00, 1'b1, 1'b1, 32'h0,   32'h77,  3'b100, 3'b000, 32'h77,  1'b1};

      reset_ni = 1'b0; flp_rd_i = 2'b00; flp_lba_i = '0; scsi_rd_i = 1'b0; scsi_wr_i = 1'b0;
      scsi_lba_i = '0; sd_busy_i = 1'b0; sd_done_i = 1'b0; sd_data_en_i = 1'b0;
      repeat (3) cyc();
      #1;
      chk("reset_outputs", all_outs(), 64'd0);
      reset_ni = 1'b1;
      cyc();

      // Table: each entry starts from IDLE; priority history is carried in the expectations.
      for (int i = 0; i < 8; i++) begin
         flp_rd_i = tbl[i].flp; scsi_rd_i = tbl[i].srd; scsi_wr_i = tbl[i].swr;
         flp_lba_i = tbl[i].flba; scsi_lba_i = tbl[i].slba;
         cyc(); #1;
         chk($sformatf("tbl%0d_sd_rd", i), 64'(sd_rd_o), 64'(tbl[i].exp_rd));
         chk($sformatf("tbl%0d_sd_wr", i), 64'(sd_wr_o), 64'(tbl[i].exp_wr));
         chk($sformatf("tbl%0d_lba", i), 64'(sd_lba_o), 64'(tbl[i].exp_lba));
         chk($sformatf("tbl%0d_busy", i), 64'({flp_busy_o, scsi_busy_o}),
             64'({~tbl[i].exp_scsi, tbl[i].exp_scsi}));
         run_xfer(tbl[i].exp_scsi, i % 4, 3 + i, 1'b0, tbl[i].exp_lba);
         release_all();
      end

      // Full 512-byte floppy block on image 1.
      flp_rd_i = 2'b10; flp_lba_i = 32'h123;
      cyc(); #1;
      chk("blk512_sd_rd", 64'(sd_rd_o), 64'(3'b010));
      chk("blk512_lba", 64'(sd_lba_o), 64'h123);
      run_xfer(1'b0, 3, 512, 1'b0, 32'h123);
      release_all();

      // Tie after a floppy win goes to SCSI; floppy held and granted two cycles after DONE.
      flp_rd_i = 2'b01; flp_lba_i = 32'h44; scsi_rd_i = 1'b1; scsi_lba_i = 32'h33;
      cyc(); #1;
      chk("handoff_first", 64'(sd_rd_o), 64'(3'b100));
      run_xfer(1'b1, 0, 2, 1'b0, 32'h33);
      scsi_rd_i = 1'b0; sd_busy_i = 1'b0;
      cyc(); #1;
      chk("handoff_idle", 64'({flp_busy_o, scsi_busy_o, sd_rd_o}), 64'd0);
      cyc(); #1;
      chk("handoff_second", 64'({sd_rd_o, flp_busy_o}), 64'({3'b001, 1'b1}));
      chk("handoff_lba", 64'(sd_lba_o), 64'h44);
      run_xfer(1'b0, 1, 1, 1'b0, 32'h44);
      release_all();

      // LBA must not follow the requester after grant.
      scsi_rd_i = 1'b1; scsi_lba_i = 32'd5;
      cyc(); #1;
      chk("latch_grant_lba", 64'(sd_lba_o), 64'd5);
      scsi_lba_i = 32'd9;
      #1;
      chk("latch_hold_lba", 64'(sd_lba_o), 64'd5);
      run_xfer(1'b1, 1, 3, 1'b0, 32'd5);
      release_all();

      // No acknowledge: 16 strobe cycles, one error pulse, no done.
      flp_rd_i = 2'b01; flp_lba_i = 32'h99;
      strobe_cyc = 0; errs = 0; dones = 0;
      cyc();
      for (int i = 0; i < 40; i++) begin
         #1;
         strobe_cyc += int'(sd_rd_o != 3'b000);
         errs  += int'(flp_err_o);
         dones += int'(flp_done_o) + int'(scsi_done_o) + int'(scsi_err_o);
         cyc();
      end
      chk("timeout_strobe_cycles", 64'(strobe_cyc), 64'd16);
      chk("timeout_err_pulses", 64'(errs), 64'd1);
      chk("timeout_no_done", 64'(dones), 64'd0);
      chk("timeout_busy_held", 64'(flp_busy_o), 64'd1);
      release_all();

      // Write-only SCSI request.
      scsi_wr_i = 1'b1; scsi_lba_i = 32'd7;
      if (WREN) begin
         cyc(); #1;
         chk("write_sd_wr", 64'(sd_wr_o), 64'(3'b100));
         chk("write_sd_rd", 64'(sd_rd_o), 64'd0);
         chk("write_lba", 64'(sd_lba_o), 64'd7);
         run_xfer(1'b1, 2, 4, 1'b0, 32'd7);
      end else begin
         bad = 0;
         for (int i = 0; i < 20; i++) begin
            cyc(); #1;
            bad += int'(scsi_busy_o) + int'(scsi_err_o) + int'(sd_wr_o != 3'b000)
                   + int'(sd_rd_o != 3'b000);
         end
         chk("write_ignored", 64'(bad), 64'd0);
      end
      release_all();

      // Reset in the middle of a transfer.
      flp_rd_i = 2'b01; flp_lba_i = 32'h42;
      cyc();
      sd_busy_i = 1'b1;
      cyc();
      sd_data_en_i = 1'b1;
      #1;
      chk("rst_pre_data_en", 64'(flp_data_en_o), 64'd1);
      reset_ni = 1'b0; sd_busy_i = 1'b0; sd_data_en_i = 1'b0;
      cyc(); #1;
      chk("rst_mid_outputs", all_outs(), 64'd0);
      reset_ni = 1'b1;
      cyc(); #1;
      chk("rst_regrant", 64'({sd_rd_o, flp_busy_o}), 64'({3'b001, 1'b1}));
      chk("rst_regrant_lba", 64'(sd_lba_o), 64'h42);
      run_xfer(1'b0, 1, 2, 1'b0, 32'h42);
      release_all();
      last_scsi = 1'b0;

      // Randomised transactions against a transaction-level round-robin model.
      for (int it = 0; it < 40; it++) begin
         f = 2'($urandom_range(0, 3)); sr = 1'($urandom_range(0, 1));
         sw = 1'($urandom_range(0, 1)); fl = $urandom(); sl = $urandom();
         flp_rd_i = f; scsi_rd_i = sr; scsi_wr_i = sw; flp_lba_i = fl; scsi_lba_i = sl;
         if (f == 2'b00 && !(sr || (sw && WREN))) begin
            cyc(); #1;
            chk("rnd_no_grant", 64'({flp_busy_o, scsi_busy_o, sd_rd_o, sd_wr_o}), 64'd0);
            release_all();
         end else begin
            if (f != 2'b00 && (sr || (sw && WREN))) win = ~last_scsi;
            else win = (f == 2'b00);
            erd = 3'b000; ewr = 3'b000;
            if (win) begin
               elba = sl;
               if (sr) erd = 3'b100; else ewr = 3'b100;
            end else begin
               elba = fl;
               erd = f[0] ? 3'b001 : 3'b010;
            end
            cyc(); #1;
            chk($sformatf("rnd%0d_sd_rd", it), 64'(sd_rd_o), 64'(erd));
            chk($sformatf("rnd%0d_sd_wr", it), 64'(sd_wr_o), 64'(ewr));
            chk($sformatf("rnd%0d_lba", it), 64'(sd_lba_o), 64'(elba));
            chk($sformatf("rnd%0d_busy", it), 64'({flp_busy_o, scsi_busy_o}), 64'({~win, win}));
            flp_lba_i = $urandom(); scsi_lba_i = $urandom();
            run_xfer(win, $urandom_range(0, 10), $urandom_range(0, 12), 1'b1, elba);
            last_scsi = win;
            release_all();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
